hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core: sits beside the decode stage and owns every stall, bubble, flush and halt decision for fetch and decode. Keeps a shadow scoreboard of the instructions in EX and MEM (destination register, load, flag-write), detects load-use, flag-before-branch and register-before-BR hazards, and orders branch flushes and halt draining against them. EX/MEM forwarding paths are outside this block; only hazards forwarding cannot cover are handled here.

---
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller beside decode: owns stall, bubble, flush and halt decisions
// for fetch/decode using a shadow scoreboard of the EX and MEM stages.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_D,
    input  logic [3:0] rr1_reg_D,
    input  logic [3:0] rr2_reg_D,
    input  logic       uses_rr1_D,
    input  logic       uses_rr2_D,
    input  logic [3:0] wr_reg_D,
    input  logic       RegWrite_D,
    input  logic       MemRead_D,
    input  logic       Flag_Enable_D,
    input  logic       BranchMux_D,
    input  logic       BranchRegMux_D,
    input  logic       branch_taken_D,
    input  logic       HaltMux_D,
    output logic       stall,
    output logic       bubble_DX,
    output logic       flush,
    output logic       halt,
    output logic       halted,
    output logic [1:0] state
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_DRAIN  = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             ex_valid_r;
    logic [3:0]       ex_wr_r;
    logic             ex_reg_write_r;
    logic             ex_mem_read_r;
    logic             ex_flag_r;
    logic             mem_valid_r;
    logic [3:0]       mem_wr_r;
    logic             mem_reg_write_r;
    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;

    logic run_s;
    logic is_branch_s;
    logic load_use_s;
    logic flag_haz_s;
    logic br_haz_s;
    logic stall_s;
    logic issue_s;
    logic halt_go_s;

    // R0 is hardwired zero, so a write to it never creates a dependency.
    function automatic logic sb_match(input logic v, input logic rw,
                                      input logic [3:0] wr, input logic [3:0] r);
        sb_match = v & rw & (wr == r) & (r != 4'd0);
    endfunction

    // Hazard detection from decode fields against the shadow scoreboard.
    always_comb begin
        run_s       = (state_r == ST_RUN);
        is_branch_s = BranchMux_D | BranchRegMux_D;
        load_use_s  = ex_mem_read_r &
                      ((uses_rr1_D & sb_match(ex_valid_r, ex_reg_write_r, ex_wr_r, rr1_reg_D)) |
                       (uses_rr2_D & sb_match(ex_valid_r, ex_reg_write_r, ex_wr_r, rr2_reg_D)));
        flag_haz_s  = is_branch_s & ex_valid_r & ex_flag_r;
        // BR reads its target in D; WB is covered by write-before-read.
        br_haz_s    = BranchRegMux_D &
                      (sb_match(ex_valid_r, ex_reg_write_r, ex_wr_r, rr1_reg_D) |
                       sb_match(mem_valid_r, mem_reg_write_r, mem_wr_r, rr1_reg_D));
        stall_s     = valid_D & run_s & (load_use_s | flag_haz_s | br_haz_s);
        issue_s     = valid_D & run_s & ~stall_s;
        halt_go_s   = issue_s & HaltMux_D;
    end

    assign stall     = ~rst & stall_s;
    assign bubble_DX = ~rst & stall_s;
    assign flush     = ~rst & issue_s & is_branch_s & branch_taken_D;
    assign halt      = ~rst & (halt_go_s | ~run_s);
    assign halted    = ~rst & (state_r == ST_HALTED);
    assign state     = rst ? ST_RUN : state_r;

    // Shadow scoreboard: MEM follows EX, EX takes the issuing D instruction or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r      <= 1'b0;
            ex_wr_r         <= 4'd0;
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            ex_flag_r       <= 1'b0;
            mem_valid_r     <= 1'b0;
            mem_wr_r        <= 4'd0;
            mem_reg_write_r <= 1'b0;
        end else begin
            mem_valid_r     <= ex_valid_r;
            mem_wr_r        <= ex_wr_r;
            mem_reg_write_r <= ex_reg_write_r;
            if (issue_s) begin
                ex_valid_r     <= 1'b1;
                ex_wr_r        <= wr_reg_D;
                ex_reg_write_r <= RegWrite_D;
                ex_mem_read_r  <= MemRead_D;
                ex_flag_r      <= Flag_Enable_D;
            end else begin
                ex_valid_r     <= 1'b0;
                ex_wr_r        <= 4'd0;
                ex_reg_write_r <= 1'b0;
                ex_mem_read_r  <= 1'b0;
                ex_flag_r      <= 1'b0;
            end
        end
    end

    // Halt sequencing: RUN until HLT issues, count out the drain, then park.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (halt_go_s) begin
                        state_r <= ST_DRAIN;
                        cnt_r   <= CNT_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_HALTED;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_HALTED: begin
                    state_r <= ST_HALTED;
                end
                default: begin
                    state_r <= ST_RUN;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios followed by
// randomized decode traffic checked against a stage-list reference model.
module tb_hazard_ctrl;

    localparam int DRAIN_CYCLES = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_D;
    logic [3:0] rr1_reg_D, rr2_reg_D, wr_reg_D;
    logic       uses_rr1_D, uses_rr2_D, RegWrite_D, MemRead_D, Flag_Enable_D;
    logic       BranchMux_D, BranchRegMux_D, branch_taken_D, HaltMux_D;
    logic       stall, bubble_DX, flush, halt, halted;
    logic [1:0] state;

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .rst(rst), .valid_D(valid_D),
        .rr1_reg_D(rr1_reg_D), .rr2_reg_D(rr2_reg_D),
        .uses_rr1_D(uses_rr1_D), .uses_rr2_D(uses_rr2_D),
        .wr_reg_D(wr_reg_D), .RegWrite_D(RegWrite_D), .MemRead_D(MemRead_D),
        .Flag_Enable_D(Flag_Enable_D), .BranchMux_D(BranchMux_D),
        .BranchRegMux_D(BranchRegMux_D), .branch_taken_D(branch_taken_D),
        .HaltMux_D(HaltMux_D), .stall(stall), .bubble_DX(bubble_DX),
        .flush(flush), .halt(halt), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    // In-flight instruction held by the reference model for one pipeline stage.
    typedef struct packed {
        logic       v;
        logic [3:0] wr;
        logic       rw;
        logic       mr;
        logic       fl;
    } slot_t;

    slot_t m_ex, m_mem;
    int    m_mode;   // 0 running, 1 draining, 2 halted
    int    m_since;  // edges since HLT left decode
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    last_stall = 1'b0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                         input logic u1, input logic u2, input logic [3:0] wr,
                         input logic rw, input logic mr, input logic fl,
                         input logic b, input logic br, input logic tk, input logic hlt);
        valid_D = v; rr1_reg_D = r1; rr2_reg_D = r2; uses_rr1_D = u1; uses_rr2_D = u2;
        wr_reg_D = wr; RegWrite_D = rw; MemRead_D = mr; Flag_Enable_D = fl;
        BranchMux_D = b; BranchRegMux_D = br; branch_taken_D = tk; HaltMux_D = hlt;
    endtask

    task automatic bubble();
        set_d(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic bit hits(input slot_t s, input logic [3:0] r);
        return s.v && s.rw && (s.wr == r) && (r != 4'd0);
    endfunction

    // One clock: predict, compare mid-cycle, then advance the model at the edge.
    task automatic step(input string tag, input int want_stall, input int want_flush);
        bit lu, fh, bh, run, e_stall, e_flush, go;
        run = !rst && valid_D && (m_mode == 0);
        lu = m_ex.mr && ((uses_rr1_D && hits(m_ex, rr1_reg_D)) || (uses_rr2_D && hits(m_ex, rr2_reg_D)));
        fh = (BranchMux_D || BranchRegMux_D) && m_ex.v && m_ex.fl;
        bh = BranchRegMux_D && (hits(m_ex, rr1_reg_D) || hits(m_mem, rr1_reg_D));
        e_stall = run && (lu || fh || bh);
        e_flush = run && !e_stall && (BranchMux_D || BranchRegMux_D) && branch_taken_D;
        go      = run && !e_stall && HaltMux_D;
        #4;
        chk({tag, "/stall"},  {3'b0, stall},     {3'b0, e_stall});
        chk({tag, "/bubble"}, {3'b0, bubble_DX}, {3'b0, e_stall});
        chk({tag, "/flush"},  {3'b0, flush},     {3'b0, e_flush});
        chk({tag, "/halt"},   {3'b0, halt},      {3'b0, !rst && (go || m_mode != 0)});
        chk({tag, "/halted"}, {3'b0, halted},    {3'b0, !rst && m_mode == 2});
        chk({tag, "/state"},  {2'b0, state},     rst ? 4'd0 : 4'(m_mode));
        if (want_stall >= 0) chk({tag, "/want_stall"}, {3'b0, stall}, 4'(want_stall));
        if (want_flush >= 0) chk({tag, "/want_flush"}, {3'b0, flush}, 4'(want_flush));
        last_stall = e_stall;
        @(posedge clk);
        if (rst) begin
            m_ex = '0; m_mem = '0; m_mode = 0; m_since = 0;
        end else begin
            m_mem = m_ex;
            m_ex  = (run && !e_stall) ? {1'b1, wr_reg_D, RegWrite_D, MemRead_D, Flag_Enable_D} : '0;
            if (go) begin
                m_mode = 1; m_since = 0;
            end else if (m_mode == 1) begin
                m_since++;
                if (m_since >= DRAIN_CYCLES) m_mode = 2;
            end
        end
        #1;
    endtask

    initial begin
        m_ex = '0; m_mem = '0; m_mode = 0; m_since = 0;
        rst = 1'b1;
        set_d(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        step("reset", 0, 0);
        rst = 1'b0;

        // Load-use: LW R3,0(R1); ADD R4,R3,R5 stalls once.
        set_d(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lw_r3", 0, 0);
        set_d(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_stall", 1, 0);
        step("lu_issue", 0, 0);
        // LW into R0 never stalls a consumer.
        set_d(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lw_r0", 0, 0);
        set_d(1'b1, 4'd0, 4'd5, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("r0_nostall", 0, 0);

        // Flag hazard: ADD R1 (flags) then taken B.
        set_d(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("add_flags", 0, 0);
        set_d(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("flag_stall", 1, 0);
        step("b_flush", 0, 1);
        bubble();
        step("b_after", 0, 0);

        // BR R7 right behind its producer: two stalls then flush.
        set_d(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("add_r7", 0, 0);
        set_d(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("br_stall_ex", 1, 0);
        step("br_stall_mem", 1, 0);
        step("br_flush", 0, 1);
        // One unrelated instruction between: one stall.
        set_d(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("add_r7b", 0, 0);
        set_d(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("add_r8", 0, 0);
        set_d(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("br_stall_one", 1, 0);
        step("br_flush2", 0, 1);

        // LW R2 then SW R2,0(R4): store data is not an EX operand.
        set_d(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lw_r2", 0, 0);
        set_d(1'b1, 4'd4, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("sw_nostall", 0, 0);

        // HLT with an empty pipeline; decode traffic during drain is ignored.
        bubble();
        step("empty1", 0, 0);
        step("empty2", 0, 0);
        set_d(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        chk("hlt_halt", {3'b0, halt}, 4'd1);
        chk("hlt_state", {2'b0, state}, 4'd0);
        step("hlt", 0, 0);
        set_d(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("drain1", 0, 0);
        step("drain2", 0, 0);
        chk("drain_not_halted", {3'b0, halted}, 4'd0);
        step("drain3", 0, 0);
        chk("halted_after3", {3'b0, halted}, 4'd1);
        chk("halted_state", {2'b0, state}, 4'd2);
        step("halted_hold1", 0, 0);
        step("halted_hold2", 0, 0);

        // Reset during drain returns to RUN with an empty scoreboard.
        rst = 1'b1;
        step("rst_halted", 0, 0);
        rst = 1'b0;
        set_d(1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lw_r3b", 0, 0);
        set_d(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("hlt2", 0, 0);
        step("drain_b1", 0, 0);
        rst = 1'b1;
        step("rst_drain", 0, 0);
        rst = 1'b0;
        set_d(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("post_rst_state", {2'b0, state}, 4'd0);
        chk("post_rst_halt", {3'b0, halt}, 4'd0);
        chk("post_rst_halted", {3'b0, halted}, 4'd0);
        step("post_rst_add", 0, 0);

        // Randomized traffic over a small register range to provoke matches.
        for (int i = 0; i < 400; i++) begin
            int kind;
            logic rw_v;
            rst = (m_mode == 2 || $urandom_range(0, 49) == 0) ? 1'b1 : 1'b0;
            if (!last_stall || rst) begin
                kind = $urandom_range(0, 9);
                rw_v = (kind > 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                set_d(1'($urandom_range(0, 3) != 0),
                      4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 3)), rw_v,
                      rw_v & 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'(kind == 0), 1'(kind == 1), 1'($urandom_range(0, 1)),
                      1'(kind == 2 && $urandom_range(0, 2) == 0));
            end
            step("rand", -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
